// File: rtl/hilo_muldiv.sv
// HI/LO register file with an iterative (shift-add / restoring divide) multiply/divide engine.
// Optional macro FAST_MUL_EN: MULT/MULTU complete in one RUN cycle via a combinational multiplier.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mag_b_q, a_q;
  logic             div_q, neg_q, neg_rem_q, divz_q;
  logic [CW-1:0]    cnt_q;
`ifdef FAST_MUL_EN
  logic [WIDTH-1:0]    b_q;
  logic                sgn_q;
  logic signed [WIDTH:0] fa, fb;
`endif

  logic               accept, start, last, commit;
  logic               op_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, res;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign op_ready = (state_q == IDLE);
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign accept   = op_valid & op_ready & ~kill;
  assign start    = accept & ~op_code[2];
  assign hi       = (accept && op_code == OP_MTHI) ? op_a : hi_q;
  assign lo       = (accept && op_code == OP_MTLO) ? op_a : lo_q;

  // Operand capture: signed ops (even codes) work on magnitudes.
  always_comb begin
    op_sgn = ~op_code[0];
    a_neg  = op_sgn & op_a[WIDTH-1];
    b_neg  = op_sgn & op_b[WIDTH-1];
    mag_a  = cond_neg(op_a, a_neg);
    mag_b  = cond_neg(op_b, b_neg);
  end

  // One iteration: multiply shifts the product right, divide shifts the quotient in left.
  always_comb begin
    sum     = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mag_b_q : {WIDTH{1'b0}})};
    shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, mag_b_q};
    if (div_q) begin
      step_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = cond_neg2({step_hi, step_lo}, neg_q);
`ifdef FAST_MUL_EN
    fa   = {sgn_q & a_q[WIDTH-1], a_q};
    fb   = {sgn_q & b_q[WIDTH-1], b_q};
    prod = (2*WIDTH)'(fa * fb);
    last = ~div_q | (cnt_q == LAST);
`else
    last = (cnt_q == LAST);
`endif
    if (!div_q)
      res = prod;
    else if (divz_q)
      res = {a_q, {WIDTH{1'b1}}};
    else
      res = {cond_neg(step_hi, neg_rem_q), cond_neg(step_lo, neg_q)};
  end

  // Control: kill always beats the final-cycle commit.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (kill) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = commit;
    if (commit)
      {hi_d, lo_d} = res;
    else if (accept && op_code == OP_MTHI)
      hi_d = op_a;
    else if (accept && op_code == OP_MTLO)
      lo_d = op_a;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded on start.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_hi_q  <= '0;
      acc_lo_q  <= mag_a;
      mag_b_q   <= mag_b;
      a_q       <= op_a;
      div_q     <= op_code[1];
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      divz_q    <= (op_b == '0);
      cnt_q     <= '0;
`ifdef FAST_MUL_EN
      b_q       <= op_b;
      sgn_q     <= op_sgn;
`endif
    end else if (state_q == RUN) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule
